// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch port I, load/store port D) in front of one in-order memory port.
// Define ARB_RR_EN to use round-robin arbitration instead of D-over-I priority with a starvation guard.
module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int MAX_OUTST  = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rdy,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [MAX_OUTST-1:0] src_fifo;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    logic                 sel_d;
    logic                 sel_i;
    logic                 accept;
    logic                 pop;
    logic                 head_d;
    logic [DATA_W-1:0]    i_rdata_q;
    logic [DATA_W-1:0]    d_rdata_q;
    logic                 err_q;

    assign full  = (count == CNT_W'(MAX_OUTST));
    assign empty = (count == '0);

`ifdef ARB_RR_EN
    logic last_d;

    // On a tie the port that did not win the previous accept goes first.
    always_comb begin
        if (i_req && d_req) sel_d = !last_d;
        else                sel_d = d_req;
    end

    always_ff @(posedge clk) begin
        if (!rst)        last_d <= 1'b1;
        else if (accept) last_d <= sel_d;
    end
`else
    localparam int STV_W = $clog2(STARVE_LIM + 1);

    logic [STV_W-1:0] starve;

    function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] v);
        return (v == STV_W'(STARVE_LIM)) ? v : v + 1'b1;
    endfunction

    assign sel_d = d_req && !(i_req && (starve == STV_W'(STARVE_LIM)));

    always_ff @(posedge clk) begin
        if (!rst)                 starve <= '0;
        else if (!i_req || i_gnt) starve <= '0;
        else if (d_gnt)           starve <= sat_inc(starve);
    end
`endif

    assign sel_i   = i_req && !sel_d;
    assign mem_req = rst && (i_req || d_req) && !full;
    assign accept  = mem_req && mem_rdy;
    assign d_gnt   = accept && sel_d;
    assign i_gnt   = accept && sel_i;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst && sel_d) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (rst && sel_i) begin
            mem_be    = 4'hF;
            mem_addr  = i_addr;
        end
    end

    // Response side: the FIFO head says who owns the returning beat.
    assign pop     = rst && mem_valid && !empty;
    assign head_d  = src_fifo[rd_ptr];
    assign i_valid = pop && !head_d;
    assign d_valid = pop && head_d;
    assign i_rdata = i_valid ? mem_rdata : i_rdata_q;
    assign d_rdata = d_valid ? mem_rdata : d_rdata_q;
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (accept) src_fifo[wr_ptr] <= sel_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (mem_valid && empty) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (i_valid) i_rdata_q <= mem_rdata;
            if (d_valid) d_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory interface between the instruction fetcher (port I) and the load/store unit (port D).
- Uses the req/rdy/valid protocol on all sides, so both requesters see their own private memory.
- Picks one requester per cycle and tracks outstanding transactions in order. Each in-order response is routed back to the requester that issued it.
- Sits between the fetch/LSU stages and the unified memory model or cache.

Parameters:
- bits, 32, address and data width
- MAX_OUTST, 4, maximum accepted-but-unanswered transactions; power of 2, minimum 2
- STARVE_LIM, 8, consecutive D grants while I is waiting before I is forced to win; minimum 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- i_req  in  1  fetch request
- i_addr  in  bits  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_valid  out  1  fetch response valid
- i_rdata  out  bits  fetch response data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  bits  data address
- d_wdata  in  bits  store data
- d_gnt  out  1  data request accepted this cycle
- d_valid  out  1  data response valid (loads and store acks)
- d_rdata  out  bits  load data
- mem_req  out  1  request to memory
- mem_we, mem_be, mem_addr, mem_wdata  out  1/4/bits/bits  selected request fields
- mem_rdy  in  1  memory accepts request
- mem_valid  in  1  one response pulse per accepted request, in order
- mem_rdata  in  bits  response data
- err  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low.
- Reset state:
  - Outstanding FIFO empty, count = 0, starvation counter = 0, err = 0.
  - All outputs 0, except i_rdata/d_rdata = 0.
- Full condition: full = (count == MAX_OUTST). When full, mem_req = 0 and no grant is issued.
- Selection (combinational, fixed priority D over I):
  - sel_D = d_req && !(i_req && starve == STARVE_LIM); otherwise sel_I = i_req.
  - mem_req = (i_req | d_req) && !full.
  - mem_* fields are muxed from the selected port. For I: mem_we = 0, mem_be = 4'hF, mem_wdata = 0.
- Acceptance and grants:
  - A request is accepted when mem_req && mem_rdy.
  - The selected port's gnt = mem_rdy && !full. The other port's gnt = 0.
  - A requester holds req and all fields stable until its gnt.
- Starvation counter:
  - Increments when D is accepted while i_req = 1.
  - Clears when I is accepted or when i_req = 0.
  - Saturates at STARVE_LIM.
- Outstanding FIFO:
  - On accept, push source ID (0 = I, 1 = D); count + 1.
  - On mem_valid, pop; count − 1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo MAX_OUTST.
- Response routing:
  - Combinational from the FIFO head on mem_valid: head = 0 gives i_valid = 1, i_rdata = mem_rdata; head = 1 gives d_valid = 1, d_rdata = mem_rdata.
  - Response data is held in a register until the next response to that same port.
  - Response latency through the arbiter is 0 cycles.
- Error: mem_valid while the FIFO is empty sets err = 1. The response is dropped and count stays 0. err clears only on reset.
- Reset mid-operation: the FIFO is flushed. The memory shares rst, so any in-flight responses are discarded by design.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin replaces fixed priority. A 1-bit last-winner register is updated on each accept. On a tie, the port that did not win last is granted. The starvation counter is not synthesised. Reset last-winner = D, so the first tie goes to I.
- Undefined: fixed D-over-I priority with the STARVE_LIM guard, as described above.

Test Plan:
1. Single fetch:
   - Stimulus: i_req = 1, i_addr = 0x100, mem_rdy = 1; mem_valid 2 cycles later with mem_rdata = 0xDEADBEEF.
   - Required: i_gnt = 1 in cycle 0; i_valid = 1 with i_rdata = 0xDEADBEEF in cycle 2; count returns to 0.
2. Simultaneous requests:
   - Stimulus: i_req = d_req = 1, d_addr = 0x200, d_we = 0, mem_rdy = 1 for 2 cycles.
   - Required: d_gnt in cycle 0, i_gnt in cycle 1. Responses 0xA then 0xB route to d_valid then i_valid in that order.
3. Full:
   - Stimulus: mem_rdy = 1, no mem_valid, d_req held high for 6 cycles.
   - Required: exactly 4 d_gnt pulses, then mem_req = 0. After one mem_valid, one more grant is issued.
4. Starvation:
   - Stimulus: STARVE_LIM = 8, both requesting continuously, mem_valid every cycle.
   - Required: 8 D grants, then 1 I grant, then the pattern repeats. With ARB_RR_EN: grants alternate I, D, I, D.
5. Push and pop in the same cycle:
   - Stimulus: with count = 2, an accept and a mem_valid occur in the same cycle.
   - Required: count stays 2; the response routes to the FIFO head ID.
6. Error and reset:
   - Stimulus: mem_valid with the FIFO empty.
   - Required: err = 1, no *_valid pulse. Then rst = 0 for 1 cycle: err = 0, count = 0.
